// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcodes, datapath widths and the writeback stage record.
package pipeline_pkg;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 4;
  localparam int FLAGS_W    = 3;
  localparam int NUM_REGS   = 16;
  localparam int OP_W       = 5;

  localparam logic [OP_W-1:0] OP_NOP   = 5'b00000;
  localparam logic [OP_W-1:0] OP_STORE = 5'b11011;

  typedef struct packed {
    logic                  vld;
    logic [OP_W-1:0]       op;
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
    logic [FLAGS_W-1:0]    flags;
  } wb_stage_t;

  // NOPs, stores and writes to r0 retire without touching architectural state.
  function automatic logic writes_reg(wb_stage_t s);
    return s.vld && (s.op != OP_NOP) && (s.op != OP_STORE) && (s.dest != '0);
  endfunction
endpackage

// File: rtl/regfile_writeback.sv
// 16x32 register file, one write port, two combinational read ports, r0 fixed at zero.
// Same-cycle write-to-read forwarding is enabled by defining WB_BYPASS_EN.
module regfile_writeback
  import pipeline_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0]     rdata1,
  output logic [DATA_W-1:0]     rdata2
);
  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     r_regs        <= '0;
    else if (we && waddr != '0)    r_regs[waddr] <= wdata;
  end

  always_comb begin
    rdata1 = (raddr1 == '0) ? '0 : r_regs[raddr1];
    rdata2 = (raddr2 == '0) ? '0 : r_regs[raddr2];
`ifdef WB_BYPASS_EN
    // write-before-read: the value being written this cycle wins over the array
    if (we && waddr != '0 && raddr1 == waddr) rdata1 = wdata;
    if (we && waddr != '0 && raddr2 == waddr) rdata2 = wdata;
`endif
  end
endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: latches the execute result, retires it into the register file and
// flags register, counts retired instructions. Optional read bypass via WB_BYPASS_EN.
module writeback_stage
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in_w,
  input  logic [OP_W-1:0]       opcode_in_w,
  input  logic [REG_ADDR_W-1:0] dest_in_w,
  input  logic [DATA_W-1:0]     data_result_in_w,
  input  logic [FLAGS_W-1:0]    flags_in_w,
  input  logic [REG_ADDR_W-1:0] rd_addr1_w,
  input  logic [REG_ADDR_W-1:0] rd_addr2_w,
  output logic [DATA_W-1:0]     rd_data1_w,
  output logic [DATA_W-1:0]     rd_data2_w,
  output logic [REG_ADDR_W-1:0] prv_inst_dest_out_w,
  output logic [DATA_W-1:0]     fwd_data_out_w,
  output logic                  fwd_valid_out_w,
  output logic [FLAGS_W-1:0]    flags_out_w,
  output logic [CNT_W-1:0]      retired_count_w
);
  wb_stage_t          r_stage;
  logic [FLAGS_W-1:0] r_flags;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_stage <= '0;
    else       r_stage <= '{vld: valid_in_w, op: opcode_in_w, dest: dest_in_w,
                            data: data_result_in_w, flags: flags_in_w};
  end

  assign w_we = writes_reg(r_stage);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_we)        r_flags <= r_stage.flags;
      if (r_stage.vld) r_cnt   <= r_cnt + 1'b1;
    end
  end

  regfile_writeback u_rf (
    .clk    (clk),
    .reset  (reset),
    .we     (w_we),
    .waddr  (r_stage.dest),
    .wdata  (r_stage.data),
    .raddr1 (rd_addr1_w),
    .raddr2 (rd_addr2_w),
    .rdata1 (rd_data1_w),
    .rdata2 (rd_data2_w)
  );

  assign fwd_valid_out_w     = w_we;
  assign prv_inst_dest_out_w = r_stage.vld ? r_stage.dest : '0;
  assign fwd_data_out_w      = r_stage.data;
  assign flags_out_w         = r_flags;
  assign retired_count_w     = r_cnt;
endmodule

// File: tb/tb_writeback_stage.sv
// Directed + randomized bench for writeback_stage against an array-based retirement model.
module tb_writeback_stage;
  localparam int CNT_W = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in_w = 1'b0;
  logic [4:0]  opcode_in_w = '0;
  logic [3:0]  dest_in_w = '0;
  logic [31:0] data_result_in_w = '0;
  logic [2:0]  flags_in_w = '0;
  logic [3:0]  rd_addr1_w = '0, rd_addr2_w = '0;
  logic [31:0] rd_data1_w, rd_data2_w, fwd_data_out_w;
  logic [3:0]  prv_inst_dest_out_w;
  logic        fwd_valid_out_w;
  logic [2:0]  flags_out_w;
  logic [CNT_W-1:0] retired_count_w;

  writeback_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .valid_in_w(valid_in_w), .opcode_in_w(opcode_in_w),
    .dest_in_w(dest_in_w), .data_result_in_w(data_result_in_w), .flags_in_w(flags_in_w),
    .rd_addr1_w(rd_addr1_w), .rd_addr2_w(rd_addr2_w), .rd_data1_w(rd_data1_w),
    .rd_data2_w(rd_data2_w), .prv_inst_dest_out_w(prv_inst_dest_out_w),
    .fwd_data_out_w(fwd_data_out_w), .fwd_valid_out_w(fwd_valid_out_w),
    .flags_out_w(flags_out_w), .retired_count_w(retired_count_w)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Reference model: architectural registers, flags, retire count, and the one in-flight slot.
  logic [31:0] m_rf [16];
  logic [2:0]  m_flags;
  int          m_cnt;
  bit          m_v;
  logic [4:0]  m_op;
  logic [3:0]  m_dest;
  logic [31:0] m_data;
  logic [2:0]  m_fl;
  int n_pass = 0, n_chk = 0;

  function automatic bit m_writes();
    return m_v && m_op != 5'd0 && m_op != 5'd27 && m_dest != 4'd0;
  endfunction

  function automatic logic [31:0] m_read(logic [3:0] a);
    if (a == 4'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (m_writes() && m_dest == a) return m_data;
`endif
    return m_rf[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    m_flags = '0; m_cnt = 0; m_v = 0; m_op = '0; m_dest = '0; m_data = '0; m_fl = '0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(string tag);
    chk({tag, ".fwd_valid"}, 32'(fwd_valid_out_w), 32'(m_writes()));
    chk({tag, ".prv_dest"}, 32'(prv_inst_dest_out_w), m_v ? 32'(m_dest) : 32'd0);
    if (m_v) chk({tag, ".fwd_data"}, fwd_data_out_w, m_data);
    chk({tag, ".flags"}, 32'(flags_out_w), 32'(m_flags));
    chk({tag, ".count"}, 32'(retired_count_w), 32'(m_cnt));
    chk({tag, ".rd1"}, rd_data1_w, m_read(rd_addr1_w));
    chk({tag, ".rd2"}, rd_data2_w, m_read(rd_addr2_w));
  endtask

  task automatic step(string tag, bit v, logic [4:0] op, logic [3:0] d, logic [31:0] data,
                      logic [2:0] fl, logic [3:0] ra1, logic [3:0] ra2);
    valid_in_w = v; opcode_in_w = op; dest_in_w = d; data_result_in_w = data;
    flags_in_w = fl; rd_addr1_w = ra1; rd_addr2_w = ra2;
    @(posedge clk);
    if (m_v) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    if (m_writes()) begin
      m_rf[m_dest] = m_data;
      m_flags = m_fl;
    end
    m_v = v; m_op = op; m_dest = d; m_data = data; m_fl = fl;
    #1 check_all(tag);
  endtask

  task automatic bubble(string tag, logic [3:0] ra1, logic [3:0] ra2);
    step(tag, 1'b0, 5'd0, 4'd0, 32'd0, 3'd0, ra1, ra2);
  endtask

  // Reset raised mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset(string tag);
    reset = 1'b1;
    #1 m_reset();
    check_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int base;
    m_reset();
    #1 check_all("reset0");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    step("add3", 1, 5'd1, 4'd3, 32'h0000_00A5, 3'b010, 4'd3, 4'd0);
    chk("add3.fwd_valid_const", 32'(fwd_valid_out_w), 32'd1);
    bubble("add3.retire", 4'd3, 4'd0);
    chk("add3.reg3_const", rd_data1_w, 32'hA5);
    chk("add3.flags_const", 32'(flags_out_w), 32'd2);
    chk("add3.count_const", 32'(retired_count_w), 32'd1);

    step("byp5", 1, 5'd2, 4'd5, 32'h0000_1234, 3'b001, 4'd5, 4'd3);
`ifdef WB_BYPASS_EN
    chk("byp5.rd1_const", rd_data1_w, 32'h1234);
`else
    chk("byp5.rd1_const", rd_data1_w, 32'h0);
`endif
    bubble("byp5.after", 4'd5, 4'd5);
    chk("byp5.after_const", rd_data1_w, 32'h1234);

    base = m_cnt;
    step("nop", 1, 5'd0, 4'd4, 32'hDEAD_BEEF, 3'b111, 4'd4, 4'd0);
    step("store", 1, 5'd27, 4'd4, 32'hCAFE_F00D, 3'b111, 4'd4, 4'd0);
    bubble("bub", 4'd4, 4'd0);
    step("wr0", 1, 5'd1, 4'd0, 32'hFFFF_FFFF, 3'b111, 4'd4, 4'd0);
    bubble("noeff", 4'd4, 4'd0);
    chk("noeff.reg4_const", rd_data1_w, 32'd0);
    chk("noeff.reg0_const", rd_data2_w, 32'd0);
    chk("noeff.flags_const", 32'(flags_out_w), 32'd1);
    chk("noeff.count_adv", 32'(retired_count_w), 32'(base + 3));

    step("b2b7a", 1, 5'd3, 4'd7, 32'h11, 3'b100, 4'd7, 4'd7);
    step("b2b7b", 1, 5'd3, 4'd7, 32'h22, 3'b101, 4'd7, 4'd7);
    bubble("b2b7c", 4'd7, 4'd7);
    chk("b2b7.rd1_const", rd_data1_w, 32'h22);
    chk("b2b7.rd2_const", rd_data2_w, 32'h22);

    for (int i = 0; i < 300; i++) begin
      logic [4:0] op;
      case ($urandom_range(0, 3))
        0: op = 5'd0;
        1: op = 5'd27;
        default: op = 5'($urandom_range(0, 31));
      endcase
      step("rand", 1'($urandom_range(0, 1)), op, 4'($urandom_range(0, 15)), $urandom,
           3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    do_reset("rst_wrap");
    for (int i = 0; i < (1 << CNT_W) - 1; i++) step("fill", 1, 5'd0, 4'd1, 32'd0, 3'd0, 4'd1, 4'd2);
    bubble("fill.end", 4'd0, 4'd0);
    chk("wrap.allones", 32'(retired_count_w), 32'((1 << CNT_W) - 1));
    step("wrap.one", 1, 5'd0, 4'd0, 32'd0, 3'd0, 4'd0, 4'd0);
    bubble("wrap.end", 4'd0, 4'd0);
    chk("wrap.zero", 32'(retired_count_w), 32'd0);

    step("pend2", 1, 5'd1, 4'd9, 32'h77, 3'b011, 4'd9, 4'd2);
    step("pend2b", 1, 5'd1, 4'd2, 32'h99, 3'b110, 4'd2, 4'd9);
    #2 do_reset("midrst");
    chk("midrst.fwd_valid_const", 32'(fwd_valid_out_w), 32'd0);
    chk("midrst.fwd_data_const", fwd_data_out_w, 32'd0);
    bubble("post.first", 4'd2, 4'd9);
    step("post.cap", 1, 5'd1, 4'd6, 32'h66, 3'b001, 4'd2, 4'd6);
    bubble("post.land", 4'd2, 4'd6);
    chk("post.reg2_const", rd_data1_w, 32'd0);
    chk("post.reg6_const", rd_data2_w, 32'h66);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset; ports are named clk and reset.
REQ-002 Parameter CNT_W, default 16: width of the retire counter.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high; clears all state.
REQ-005 valid_in_w  input  1  execute output is a real instruction (0 = bubble).
REQ-006 opcode_in_w  input  5  opcode of the retiring instruction.
REQ-007 dest_in_w  input  4  destination register index.
REQ-008 data_result_in_w  input  32  execute result.
REQ-009 flags_in_w  input  3  execute flags.
REQ-010 rd_addr1_w, rd_addr2_w  input  4 each  decode-stage read addresses.
REQ-011 rd_data1_w, rd_data2_w  output  32 each  register read data.
REQ-012 prv_inst_dest_out_w  output  4  dest held in the stage register, for execute-side forwarding.
REQ-013 fwd_data_out_w  output  32  result held in the stage register.
REQ-014 fwd_valid_out_w  output  1  stage register holds a register-writing instruction.
REQ-015 flags_out_w  output  3  architectural flags register.
REQ-016 retired_count_w  output  CNT_W  count of valid instructions retired.

Function
REQ-017 Stage register: each rising edge captures valid_in_w, opcode, dest, result and flags; when valid_in_w=0, stage valid SHALL be 0 and the other fields are don't-care.
REQ-018 wb_we = stage valid AND opcode not OP_NOP (00000) AND opcode not OP_STORE (11011) AND dest != 0.
REQ-019 When wb_we=1, the register file SHALL write fwd data to reg[dest] on the next rising edge; total latency from execute output to architectural state is 2 edges.
REQ-020 Register 0 SHALL read as 0; writes to it are ignored.
REQ-021 Reads SHALL be combinational from rd_addr1_w/rd_addr2_w; both ports are independent and may use the same address.
REQ-022 fwd_valid_out_w = wb_we; prv_inst_dest_out_w = stage dest when stage valid, else 0; fwd_data_out_w = stage result.
REQ-023 flags_out_w SHALL load stage flags on the edge that performs a write with wb_we=1; it is unchanged otherwise, including for NOP, STORE and bubbles.
REQ-024 retired_count_w SHALL increment by 1 on every edge where stage valid=1 (including NOP and STORE), and wrap from all-ones to 0.
REQ-025 Back-to-back writes to the same dest SHALL leave the later value in the register file; no write is dropped.

Reset
REQ-026 While reset=1: stage valid=0, stage fields=0, all 16 registers=0, flags_out_w=0, retired_count_w=0; all outputs read 0.
REQ-027 Reset asserted mid-operation SHALL discard any pending stage write; the write SHALL NOT reach the register file.
REQ-028 On the first edge after reset deassertion, the stage register captures its inputs normally.

Configuration
REQ-029 Macro WB_BYPASS_EN defined: a read whose address equals the stage dest while wb_we=1 SHALL return fwd_data_out_w in the same cycle (write-before-read).
REQ-030 WB_BYPASS_EN undefined: reads return array contents only; the new value is visible from the cycle after the write edge.

Structure
REQ-031 Shared package pipeline_pkg SHALL hold OP_NOP, OP_STORE, DATA_W=32, REG_ADDR_W=4, FLAGS_W=3 and NUM_REGS=16.
REQ-032 Register file SHALL be sub-module regfile_writeback: 16x32 array, 1 write port, 2 read ports, r0 hardwired to 0, bypass under WB_BYPASS_EN.

Verification
REQ-033 Reset, then present valid add dest=3 result=32'h0000_00A5 flags=3'b010 -> fwd_valid_out_w=1 after edge 1; reg3=0xA5 and flags_out_w=010 after edge 2; retired_count_w=1.
REQ-034 Present dest=5 result=0x1234 with rd_addr1_w=5 during the stage cycle -> rd_data1_w=0x1234 with WB_BYPASS_EN, 0 without; 0x1234 in both builds one cycle later.
REQ-035 Present NOP, STORE (dest=4), a bubble, and a write to dest=0 with 0xFFFF_FFFF -> reg4, reg0 and flags unchanged; retired_count_w advances by 3.
REQ-036 Write dest=7 with 0x11 then 0x22 on consecutive cycles -> reg7 ends at 0x22; rd_addr1_w=rd_addr2_w=7 both read 0x22.
REQ-037 Preload retired_count_w to all-ones via 2^CNT_W-1 valid instructions, then one more -> wraps to 0.
REQ-038 Assert reset in the cycle after capturing dest=2 result=0x99 -> reg2 stays 0; all outputs are 0 asynchronously, before the next clock edge.
